// File: rtl/mac_neuron_accumulator.sv
// Sequential multiply-accumulate neuron core: accumulates data*weight over an in_last-terminated
// vector, then rescales (floor shift) and saturates onto a valid/ready output. Option: MAC_BIAS_EN.
module mac_neuron_accumulator #(
    parameter int precision = 16,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 40
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [precision-1:0] in_data,
    input  logic signed [precision-1:0] in_weight,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [precision-1:0] out_data
`ifdef MAC_BIAS_EN
    ,
    input  logic signed [precision-1:0] bias
`endif
);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic signed [ACC_W-1:0] L_SAT_MAX =
        {{(ACC_W-precision+1){1'b0}}, {(precision-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] L_SAT_MIN =
        {{(ACC_W-precision+1){1'b1}}, {(precision-1){1'b0}}};

    function automatic logic signed [precision-1:0] sat_q(input logic signed [ACC_W-1:0] v);
        logic signed [precision-1:0] res;
        if (v > L_SAT_MAX) begin
            res = L_SAT_MAX[precision-1:0];
        end else if (v < L_SAT_MIN) begin
            res = L_SAT_MIN[precision-1:0];
        end else begin
            res = v[precision-1:0];
        end
        return res;
    endfunction

    state_t                         r_state;
    logic signed [ACC_W-1:0]        r_acc;
    logic signed [precision-1:0]    r_out_data;
    logic                           r_out_valid;
    logic                           r_in_ready;

    state_t                         w_state_nxt;
    logic signed [ACC_W-1:0]        w_acc_nxt;
    logic signed [precision-1:0]    w_out_data_nxt;
    logic                           w_out_valid_nxt;
    logic                           w_in_ready_nxt;

    logic                           w_accept;
    logic                           w_handshake;
    logic signed [2*precision-1:0]  w_prod;
    logic signed [ACC_W-1:0]        w_prod_ext;
    logic signed [ACC_W-1:0]        w_base;
    logic signed [ACC_W-1:0]        w_sum;
    logic signed [ACC_W-1:0]        w_scaled;

    assign w_accept    = in_valid && r_in_ready;
    assign w_handshake = r_out_valid && out_ready;
    assign w_prod      = in_data * in_weight;
    assign w_prod_ext  = {{(ACC_W-2*precision){w_prod[2*precision-1]}}, w_prod};

`ifdef MAC_BIAS_EN
    logic                    r_first;
    logic signed [ACC_W-1:0] w_bias_ext;

    assign w_bias_ext = {{(ACC_W-precision){bias[precision-1]}}, bias} <<< FRAC_BITS;
    // The bias replaces the (already cleared) accumulator only on the first beat of a vector.
    assign w_base     = r_first ? w_bias_ext : r_acc;

    // First-beat flag: armed by reset and by each result handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_first <= 1'b1;
        end else if (w_handshake) begin
            r_first <= 1'b1;
        end else if (w_accept) begin
            r_first <= 1'b0;
        end else begin
            r_first <= r_first;
        end
    end
`else
    assign w_base = r_acc;
`endif

    assign w_sum    = w_base + w_prod_ext;
    assign w_scaled = w_sum >>> FRAC_BITS;

    // Next-state and next-output decode for the ACCUM/HOLD controller.
    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;
        w_in_ready_nxt  = r_in_ready;
        case (r_state)
            ST_ACCUM: begin
                w_in_ready_nxt  = 1'b1;
                w_out_valid_nxt = 1'b0;
                if (w_accept) begin
                    w_acc_nxt = w_sum;
                    if (in_last) begin
                        w_state_nxt     = ST_HOLD;
                        w_out_data_nxt  = sat_q(w_scaled);
                        w_out_valid_nxt = 1'b1;
                        w_in_ready_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = ST_ACCUM;
                    end
                end else begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (w_handshake) begin
                    w_state_nxt     = ST_ACCUM;
                    w_acc_nxt       = {ACC_W{1'b0}};
                    w_out_valid_nxt = 1'b0;
                    w_in_ready_nxt  = 1'b1;
                end else begin
                    w_out_valid_nxt = 1'b1;
                    w_in_ready_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt     = ST_ACCUM;
                w_acc_nxt       = {ACC_W{1'b0}};
                w_out_valid_nxt = 1'b0;
                w_in_ready_nxt  = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_acc       <= {ACC_W{1'b0}};
            r_out_data  <= {precision{1'b0}};
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_in_ready  <= w_in_ready_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_mac_neuron_accumulator.sv
// Self-checking bench for mac_neuron_accumulator: directed cases plus random vectors checked
// against an arithmetic reference model (floor division and clamp). Honours MAC_BIAS_EN.
module tb_mac_neuron_accumulator;

    localparam int P  = 16;
    localparam int F  = 8;
    localparam int AW = 40;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic signed [P-1:0] in_data;
    logic signed [P-1:0] in_weight;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic signed [P-1:0] out_data;
`ifdef MAC_BIAS_EN
    logic signed [P-1:0] bias;
`endif

    int     checks   = 0;
    int     failures = 0;
    int     vd[16];
    int     vw[16];
    int     vlen;
    longint bias_val = 0;

    always #5 clk = ~clk;

    mac_neuron_accumulator #(.precision(P), .FRAC_BITS(F), .ACC_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_weight (in_weight),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef MAC_BIAS_EN
        ,
        .bias      (bias)
`endif
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: exact sum of products plus bias*1.0, floor-divided by 2^F, clamped to P bits.
    function automatic longint model();
        longint s;
        longint q;
        s = bias_val * 256;
        for (int i = 0; i < vlen; i++) s += longint'(vd[i]) * longint'(vw[i]);
        q = s / 256;
        if ((s % 256 != 0) && (s < 0)) q = q - 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return q;
    endfunction

    task automatic run_vector(input string tag, input longint exp, input int hold, input int gap_max);
`ifdef MAC_BIAS_EN
        bias = P'(bias_val);
`endif
        out_ready = (hold == 0);
        for (int i = 0; i < vlen; i++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_last  = 1'b1;
                    in_data  = P'($urandom);
                end
            end
            @(negedge clk);
            chk({tag, "_in_ready_accum"}, in_ready, 1);
            in_valid  = 1'b1;
            in_data   = P'(vd[i]);
            in_weight = P'(vw[i]);
            in_last   = (i == vlen - 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_out_data"}, out_data, exp);
        chk({tag, "_in_ready_hold"}, in_ready, 0);
        repeat (hold) begin
            @(negedge clk);
            chk({tag, "_held_valid"}, out_valid, 1);
            chk({tag, "_held_data"}, out_data, exp);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_valid_drop"}, out_valid, 0);
        chk({tag, "_in_ready_back"}, in_ready, 1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_weight = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
`ifdef MAC_BIAS_EN
        bias      = '0;
`endif
        repeat (2) @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_data", out_data, 0);
        rst = 1'b0;

        // Basic three-beat vector.
        vlen = 3;
        vd[0] = 256; vd[1] = 512; vd[2] = 768;
        vw[0] = 256; vw[1] = 256; vw[2] = 256;
        run_vector("t1_basic", 1536, 0, 0);

        // Positive and negative saturation.
        vlen = 4;
        for (int i = 0; i < 4; i++) begin vd[i] = 32767; vw[i] = 32767; end
        run_vector("t2_sat_pos", 32767, 0, 0);
        for (int i = 0; i < 4; i++) vw[i] = -32767;
        run_vector("t2_sat_neg", -32768, 0, 0);

        // Single-beat vectors, floor rounding of a negative sub-LSB value.
        vlen = 1;
        vd[0] = -512; vw[0] = 256;
        run_vector("t3_single", -512, 0, 0);
        vd[0] = -1; vw[0] = 1;
        run_vector("t3_floor", -1, 0, 0);

        // Backpressure with an input beat offered during HOLD.
        out_ready = 1'b0;
        @(negedge clk); in_valid = 1'b1; in_data = 16'sd1000; in_weight = 16'sd256; in_last = 1'b0;
        @(negedge clk); in_data = -16'sd300; in_weight = 16'sd512; in_last = 1'b1;
        @(negedge clk); in_data = 16'sd2560; in_weight = 16'sd256; in_last = 1'b1;
        chk("t4_valid", out_valid, 1);
        chk("t4_data", out_data, 400);
        repeat (5) begin
            @(negedge clk);
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_ready", in_ready, 0);
            chk("t4_hold_data", out_data, 400);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_release_valid", out_valid, 0);
        chk("t4_release_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        chk("t4_offered_valid", out_valid, 1);
        chk("t4_offered_data", out_data, 2560);
        @(negedge clk);
        chk("t4_offered_drop", out_valid, 0);

        // Reset mid-vector discards the partial sum.
        @(negedge clk); in_valid = 1'b1; in_data = 16'sd1000; in_weight = 16'sd256; in_last = 1'b0;
        @(negedge clk); in_data = 16'sd700;
        @(negedge clk); in_valid = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_ready", in_ready, 1);
        chk("t5_rst_data", out_data, 0);
        vlen = 1; vd[0] = 256; vw[0] = 256;
        run_vector("t5_after_rst", 256, 0, 0);

        // Bias on a single-beat vector.
        bias_val = 256;
`ifdef MAC_BIAS_EN
        run_vector("t6_bias", 512, 0, 0);
`else
        run_vector("t6_nobias", 256, 0, 0);
`endif
        bias_val = 0;

        // Random vectors with gaps and backpressure.
        for (int v = 0; v < 30; v++) begin
            vlen = int'($urandom_range(1, 6));
            for (int i = 0; i < vlen; i++) begin
                vd[i] = int'($urandom_range(0, 65535)) - 32768;
                vw[i] = int'($urandom_range(0, 65535)) - 32768;
            end
`ifdef MAC_BIAS_EN
            bias_val = longint'($urandom_range(0, 65535)) - 32768;
`endif
            run_vector("rnd", model(), int'($urandom_range(0, 3)), 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
